// File: rtl/seg7_rx_checker.sv
// seg7_rx_checker: watches an asynchronous 7-segment bus, debounces it,
// decodes digits 0..7 and checks that they arrive as an incrementing
// (mod 8) sequence. Reports decoded digits, lock state and error events.
module seg7_rx_checker #(
    parameter int STABLE_CYCLES = 4,    // legal 2..15
    parameter int TIMEOUT       = 1024  // legal 2..65535
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [6:0] seg_in,
    output logic [2:0] digit_out,
    output logic       digit_valid,
    output logic       locked,
    output logic       seq_err,
    output logic       invalid_pat,
    output logic [7:0] err_count
);

    typedef enum logic {
        HUNT  = 1'b0,
        TRACK = 1'b1
    } state_t;

    localparam logic [3:0]  STAB_MAX = 4'(STABLE_CYCLES);
    localparam logic [15:0] TO_LAST  = 16'(TIMEOUT - 1);
    localparam logic [6:0]  BLANK    = 7'h00;

    // Returns {is_digit, digit} for one segment pattern.
    function automatic logic [3:0] decode(input logic [6:0] pat);
        logic [3:0] res;
        case (pat)
            7'h3F:   res = {1'b1, 3'd0};
            7'h06:   res = {1'b1, 3'd1};
            7'h5B:   res = {1'b1, 3'd2};
            7'h4F:   res = {1'b1, 3'd3};
            7'h66:   res = {1'b1, 3'd4};
            7'h6D:   res = {1'b1, 3'd5};
            7'h7C:   res = {1'b1, 3'd6};
            7'h07:   res = {1'b1, 3'd7};
            default: res = 4'b0000;
        endcase
        return res;
    endfunction

    // Registered state
    state_t     state;
    logic [6:0] seg_meta;
    logic [6:0] seg_s;
    logic [6:0] seg_prev;
    logic [3:0] stab_cnt;
    logic [6:0] last_acc;
    logic [15:0] tmo_cnt;
    logic [2:0] expected;

    // Next-state values
    state_t     state_next;
    logic [3:0] stab_next;
    logic [6:0] last_next;
    logic [15:0] tmo_next;
    logic [2:0] exp_next;
    logic [2:0] digit_next;
    logic       valid_next;
    logic       seq_next;
    logic       inv_next;
    logic [7:0] err_next;
    logic       err_inc;
    logic       accept;
    logic [3:0] dec;

    // Stability counter and acceptance: a pattern is taken once, in the cycle
    // its run of identical samples reaches STABLE_CYCLES, if it is new.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        stab_next = 4'd1;
        accept    = 1'b0;
        if (seg_s == seg_prev) begin
            stab_next = (stab_cnt == STAB_MAX) ? STAB_MAX : stab_cnt + 4'd1;
            accept    = (stab_cnt == STAB_MAX - 4'd1) && (seg_s != last_acc);
        end
        dec = decode(seg_s);
    end

    // FSM next state plus next values of every registered output.
    always_comb begin
        state_next = state;
        last_next  = last_acc;
        tmo_next   = tmo_cnt;
        exp_next   = expected;
        digit_next = digit_out;
        valid_next = 1'b0;
        seq_next   = 1'b0;
        inv_next   = 1'b0;
        err_inc    = 1'b0;
        err_next   = err_count;

        if (accept) begin
            // Acceptance wins over a timeout expiring in the same cycle.
            last_next = seg_s;
            tmo_next  = 16'd0;
            if (seg_s == BLANK) begin
                // Blank only refreshes the last accepted pattern.
            end else if (dec[3]) begin
                valid_next = 1'b1;
                digit_next = dec[2:0];
                exp_next   = dec[2:0] + 3'd1;
                state_next = TRACK;
                if (state == TRACK && dec[2:0] != expected) begin
                    seq_next = 1'b1;
                    err_inc  = 1'b1;
                end
            end else begin
                inv_next   = 1'b1;
                err_inc    = 1'b1;
                state_next = HUNT;
            end
        end else if (state == TRACK) begin
            if (tmo_cnt == TO_LAST) begin
                state_next = HUNT;
                tmo_next   = 16'd0;
            end else begin
                tmo_next = tmo_cnt + 16'd1;
            end
        end else begin
            tmo_next = 16'd0;
        end

        if (err_inc && err_count != 8'hFF) begin
            err_next = err_count + 8'd1;
        end
    end

    // All state and outputs registered; synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (!rstn) begin
            state       <= HUNT;
            seg_meta    <= 7'h00;
            seg_s       <= 7'h00;
            seg_prev    <= 7'h00;
            stab_cnt    <= 4'd0;
            last_acc    <= BLANK;
            tmo_cnt     <= 16'd0;
            expected    <= 3'd0;
            digit_out   <= 3'd0;
            digit_valid <= 1'b0;
            seq_err     <= 1'b0;
            invalid_pat <= 1'b0;
            err_count   <= 8'd0;
        end else begin
            state       <= state_next;
            seg_meta    <= seg_in;
            seg_s       <= seg_meta;
            seg_prev    <= seg_s;
            stab_cnt    <= stab_next;
            last_acc    <= last_next;
            tmo_cnt     <= tmo_next;
            expected    <= exp_next;
            digit_out   <= digit_next;
            digit_valid <= valid_next;
            seq_err     <= seq_next;
            invalid_pat <= inv_next;
            err_count   <= err_next;
        end
    end

    assign locked = (state == TRACK);

endmodule

// File: tb/tb_seg7_rx_checker.sv
// Directed testbench for seg7_rx_checker (STABLE_CYCLES=4, TIMEOUT=16).
module tb_seg7_rx_checker;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [6:0] seg_in = 7'h00;
    logic [2:0] digit_out;
    logic       digit_valid;
    logic       locked;
    logic       seq_err;
    logic       invalid_pat;
    logic [7:0] err_count;

    int checks = 0;
    int errors = 0;

    // Event log filled while stepping
    int n_valid, n_seq, n_inv, n_orphan, n_both;
    logic [2:0] digits[$];

    seg7_rx_checker #(.STABLE_CYCLES(4), .TIMEOUT(16)) dut (
        .clk(clk), .rstn(rstn), .seg_in(seg_in),
        .digit_out(digit_out), .digit_valid(digit_valid), .locked(locked),
        .seq_err(seq_err), .invalid_pat(invalid_pat), .err_count(err_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic clear_log();
        n_valid = 0; n_seq = 0; n_inv = 0; n_orphan = 0; n_both = 0;
        digits.delete();
    endtask

    // One clock edge, then sample 1 ns later and log event pulses.
    task automatic step();
        @(posedge clk);
        #1;
        if (digit_valid) begin
            n_valid++;
            digits.push_back(digit_out);
        end
        if (seq_err) begin
            n_seq++;
            if (!digit_valid) n_orphan++;
        end
        if (invalid_pat) n_inv++;
        if (seq_err && invalid_pat) n_both++;
    endtask

    task automatic hold(input logic [6:0] pat, input int n);
        seg_in = pat;
        repeat (n) step();
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        seg_in = 7'h00;
        step();
        step();
        rstn = 1'b1;
        clear_log();
    endtask

    task automatic test_reset();
        do_reset();
        hold(7'h3F, 10);
        hold(7'h66, 10);
        checks++;
        if (err_count !== 8'd1) begin errors++; $display("FAIL pre_reset_err_count: got %0d expected 1", err_count); end
        rstn = 1'b0;
        step();
        checks++;
        if (digit_out !== 3'd0) begin errors++; $display("FAIL reset_digit_out: got %0d expected 0", digit_out); end
        checks++;
        if ({digit_valid, locked, seq_err, invalid_pat} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags: got %b expected 0000", {digit_valid, locked, seq_err, invalid_pat});
        end
        checks++;
        if (err_count !== 8'd0) begin errors++; $display("FAIL reset_err_count: got %0d expected 0", err_count); end
        rstn = 1'b1;
    endtask

    task automatic test_reset_midcount();
        int first;
        do_reset();
        seg_in = 7'h06;
        repeat (4) step();
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        clear_log();
        first = 0;
        for (int c = 1; c <= 8; c++) begin
            step();
            if (digit_valid && first == 0) first = c;
        end
        checks++;
        if (first !== 6) begin errors++; $display("FAIL midcount_restart_cycle: got %0d expected 6", first); end
    endtask

    task automatic test_first_digit();
        int first;
        logic [2:0] d_at6;
        logic lk5, lk7;
        do_reset();
        seg_in = 7'h3F;
        first = 0; d_at6 = 3'd7; lk5 = 1'b1; lk7 = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            step();
            if (digit_valid && first == 0) first = c;
            if (c == 5) lk5 = locked;
            if (c == 6) d_at6 = digit_out;
            if (c == 7) lk7 = locked;
        end
        checks++;
        if (first !== 6) begin errors++; $display("FAIL first_valid_cycle: got %0d expected 6", first); end
        checks++;
        if (d_at6 !== 3'd0) begin errors++; $display("FAIL first_digit: got %0d expected 0", d_at6); end
        checks++;
        if ({lk5, lk7} !== 2'b01) begin errors++; $display("FAIL first_lock: got %b expected 01", {lk5, lk7}); end
        checks++;
        if (n_valid !== 1 || n_seq !== 0) begin
            errors++; $display("FAIL first_events: got valid=%0d seq=%0d expected 1,0", n_valid, n_seq);
        end
    endtask

    task automatic test_sequence();
        logic [6:0] pats[9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7C, 7'h07, 7'h3F};
        int bad;
        do_reset();
        foreach (pats[i]) hold(pats[i], 10);
        bad = 0;
        if (digits.size() == 9) begin
            foreach (digits[i]) if (digits[i] !== 3'(i % 8)) bad++;
        end
        checks++;
        if (digits.size() !== 9) begin errors++; $display("FAIL seq_count: got %0d expected 9", digits.size()); end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL seq_digits: got %0d wrong expected 0 wrong", bad); end
        checks++;
        if (n_seq !== 0 || err_count !== 8'd0 || locked !== 1'b1) begin
            errors++; $display("FAIL seq_clean: got seq=%0d err=%0d locked=%b expected 0,0,1", n_seq, err_count, locked);
        end
    endtask

    task automatic test_glitch();
        do_reset();
        hold(7'h3F, 10);
        clear_log();
        for (int g = 1; g <= 3; g++) begin
            hold(7'h06, g);
            hold(7'h3F, 8);
        end
        checks++;
        if (n_valid !== 0 || n_inv !== 0) begin
            errors++; $display("FAIL glitch_events: got valid=%0d inv=%0d expected 0,0", n_valid, n_inv);
        end
        checks++;
        if (digit_out !== 3'd0) begin errors++; $display("FAIL glitch_digit: got %0d expected 0", digit_out); end
        // A 4-cycle pulse is exactly long enough to be accepted.
        hold(7'h06, 4);
        hold(7'h3F, 8);
        checks++;
        if (n_valid !== 2) begin errors++; $display("FAIL glitch4_count: got %0d expected 2", n_valid); end
        else begin
            checks++;
            if (digits[0] !== 3'd1 || digits[1] !== 3'd0) begin
                errors++; $display("FAIL glitch4_digits: got %0d,%0d expected 1,0", digits[0], digits[1]);
            end
        end
    endtask

    task automatic test_seq_err_and_invalid();
        do_reset();
        hold(7'h3F, 10);
        hold(7'h06, 10);
        hold(7'h5B, 10);
        clear_log();
        hold(7'h66, 10);
        checks++;
        if (digit_out !== 3'd4 || n_valid !== 1) begin
            errors++; $display("FAIL skip_digit: got digit=%0d valid=%0d expected 4,1", digit_out, n_valid);
        end
        checks++;
        if (n_seq !== 1 || n_orphan !== 0) begin
            errors++; $display("FAIL skip_seq_err: got seq=%0d orphan=%0d expected 1,0", n_seq, n_orphan);
        end
        checks++;
        if (err_count !== 8'd1 || locked !== 1'b1) begin
            errors++; $display("FAIL skip_state: got err=%0d locked=%b expected 1,1", err_count, locked);
        end
        hold(7'h6D, 10);
        checks++;
        if (n_seq !== 1 || digit_out !== 3'd5 || err_count !== 8'd1) begin
            errors++; $display("FAIL resync_next5: got seq=%0d digit=%0d err=%0d expected 1,5,1", n_seq, digit_out, err_count);
        end
        hold(7'h7F, 10);
        checks++;
        if (n_inv !== 1 || err_count !== 8'd2) begin
            errors++; $display("FAIL invalid_pulse: got inv=%0d err=%0d expected 1,2", n_inv, err_count);
        end
        checks++;
        if (locked !== 1'b0 || digit_out !== 3'd5 || n_valid !== 2 || n_both !== 0) begin
            errors++; $display("FAIL invalid_state: got locked=%b digit=%0d valid=%0d both=%0d expected 0,5,2,0",
                               locked, digit_out, n_valid, n_both);
        end
    endtask

    task automatic test_blank();
        do_reset();
        hold(7'h3F, 10);
        hold(7'h00, 10);
        checks++;
        if (n_valid !== 1 || locked !== 1'b1) begin
            errors++; $display("FAIL blank_no_event: got valid=%0d locked=%b expected 1,1", n_valid, locked);
        end
        hold(7'h3F, 10);
        checks++;
        if (n_valid !== 2 || n_seq !== 1 || err_count !== 8'd1 || digit_out !== 3'd0) begin
            errors++; $display("FAIL blank_reaccept: got valid=%0d seq=%0d err=%0d digit=%0d expected 2,1,1,0",
                               n_valid, n_seq, err_count, digit_out);
        end
    endtask

    task automatic test_timeout();
        int d;
        logic found, lost;
        do_reset();
        seg_in = 7'h3F;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (digit_valid) found = 1'b1;
        end
        checks++;
        if (!found) begin errors++; $display("FAIL timeout_lock: got no digit_valid expected one within 20 cycles"); end
        d = 0; lost = 1'b0;
        for (int i = 0; i < 40 && !lost; i++) begin
            step();
            d++;
            if (!locked) lost = 1'b1;
        end
        checks++;
        if (!lost || d !== 16) begin errors++; $display("FAIL timeout_latency: got %0d (lost=%b) expected 16", d, lost); end
        checks++;
        if (n_seq !== 0 || n_inv !== 0 || err_count !== 8'd0) begin
            errors++; $display("FAIL timeout_no_err: got seq=%0d inv=%0d err=%0d expected 0,0,0", n_seq, n_inv, err_count);
        end
    endtask

    task automatic test_timeout_priority();
        do_reset();
        hold(7'h3F, 16);
        hold(7'h06, 6);
        checks++;
        if (digit_valid !== 1'b1 || digit_out !== 3'd1 || locked !== 1'b1 || seq_err !== 1'b0) begin
            errors++; $display("FAIL prio_accept: got valid=%b digit=%0d locked=%b seq=%b expected 1,1,1,0",
                               digit_valid, digit_out, locked, seq_err);
        end
        repeat (15) step();
        checks++;
        if (locked !== 1'b1) begin errors++; $display("FAIL prio_timer_cleared: got locked=%b expected 1", locked); end
        step();
        checks++;
        if (locked !== 1'b0) begin errors++; $display("FAIL prio_timeout_after: got locked=%b expected 0", locked); end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 300; i++) hold((i % 2 == 0) ? 7'h7F : 7'h77, 5);
        repeat (6) step();
        checks++;
        if (err_count !== 8'd255) begin errors++; $display("FAIL sat_err_count: got %0d expected 255", err_count); end
        checks++;
        if (n_inv !== 300 || n_seq !== 0 || n_both !== 0) begin
            errors++; $display("FAIL sat_pulses: got inv=%0d seq=%0d both=%0d expected 300,0,0", n_inv, n_seq, n_both);
        end
    endtask

    initial begin
        clear_log();
        test_reset();
        test_reset_midcount();
        test_first_digit();
        test_sequence();
        test_glitch();
        test_seq_err_and_invalid();
        test_blank();
        test_timeout();
        test_timeout_priority();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_rx_checker.md
SEG7_RX_CHECKER -- requirements
Module: seg7_rx_checker

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, meaning consecutive identical synchronized samples needed to accept a pattern (legal 2..15).
REQ-002 SHALL have parameter TIMEOUT, default 1024, meaning cycles in TRACK with no digit event before lock is dropped (legal 2..65535).
REQ-003 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port rstn  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port seg_in  input  7  asynchronous segment pattern from pads, bit0 = segment a ... bit6 = segment g.
REQ-006 SHALL have port digit_out  output  3  last decoded digit, held between events.
REQ-007 SHALL have port digit_valid  output  1  one-cycle pulse when digit_out is updated.
REQ-008 SHALL have port locked  output  1  high while the FSM is in TRACK.
REQ-009 SHALL have port seq_err  output  1  one-cycle pulse when a digit does not follow the expected count.
REQ-010 SHALL have port invalid_pat  output  1  one-cycle pulse when an accepted pattern is not in the code table.
REQ-011 SHALL have port err_count  output  8  saturating count of seq_err plus invalid_pat events.

Function
REQ-012 SHALL pass seg_in through a two-flop synchronizer; seg_s is seg_in delayed 2 cycles.
REQ-013 SHALL run a stability counter that resets to 1 when seg_s differs from its previous sample and increments (saturating at STABLE_CYCLES) when it matches.
REQ-014 SHALL accept seg_s once, in the cycle the counter reaches STABLE_CYCLES, and only if seg_s differs from the last accepted pattern.
REQ-015 SHALL register all event outputs, so a held new pattern on seg_in gives its event pulse in cycle 2+STABLE_CYCLES after first presentation (6 cycles at default).
REQ-016 SHALL decode accepted patterns as 0x3F->0, 0x06->1, 0x5B->2, 0x4F->3, 0x66->4, 0x6D->5, 0x7C->6, 0x07->7.
REQ-017 SHALL treat 0x00 (blank) as accepted with no event: it updates the last accepted pattern and nothing else.
REQ-018 SHALL treat any other accepted pattern as invalid: pulse invalid_pat, increment err_count, go to HUNT, leave digit_out unchanged.
REQ-019 SHALL implement the FSM state HUNT (locked=0): a valid digit D drives digit_valid and digit_out=D, sets expected=(D+1) mod 8, and moves to TRACK with no seq_err.
REQ-020 SHALL implement the FSM state TRACK (locked=1): a valid digit D drives digit_valid and digit_out=D.
REQ-021 SHALL, in TRACK, pulse seq_err and increment err_count when D != expected, in the same cycle as digit_valid.
REQ-022 SHALL, in TRACK, set expected=(D+1) mod 8 in both the match and mismatch cases, and stay in TRACK.
REQ-023 SHALL wrap 7 to 0 as a legal sequence step, with no error.
REQ-024 SHALL run a timeout counter that clears on every accepted pattern (including blank and invalid) and increments in TRACK.
REQ-025 SHALL, when the timeout counter reaches TIMEOUT-1 with no accepted pattern, go to HUNT (locked=0) with no error pulse.
REQ-026 SHALL hold the timeout counter at 0 in HUNT.
REQ-027 SHALL saturate err_count at 255 and keep pulsing seq_err/invalid_pat while saturated.
REQ-028 SHALL never assert seq_err and invalid_pat in the same cycle, and SHALL never increment err_count by more than 1 per cycle.
REQ-029 SHALL give an acceptance in the same cycle as timeout expiry priority: the acceptance is processed in TRACK and the timeout is ignored.

Reset
REQ-030 SHALL, with rstn=0 at a clock edge, clear the synchronizer, stability counter, timeout counter, expected and last accepted pattern (to 0x00) and enter HUNT.
REQ-031 SHALL drive digit_out=0, digit_valid=0, locked=0, seq_err=0, invalid_pat=0, err_count=0 in the cycle after a reset edge.
REQ-032 SHALL abort any in-progress stability count on a mid-operation reset, with no event from a pattern partially counted before reset.

Verification
REQ-033 SHALL be verified by: seg_in=0x3F held from reset release -> digit_valid pulse in cycle 6 with digit_out=0 and locked=1 in the following cycle, seq_err=0.
REQ-034 SHALL be verified by: sequence 0x3F,0x06,...,0x07,0x3F, each held 10 cycles -> 9 digit_valid pulses with digits 0..7,0, seq_err never high, err_count=0.
REQ-035 SHALL be verified by: 1-, 2- and 3-cycle glitches to 0x06 during a 0x3F hold -> no event, digit_out stays 0.
REQ-036 SHALL be verified by: locked at digit 2, then 0x66 -> digit_out=4, seq_err pulse, err_count=1, expected next 5, locked stays 1.
REQ-037 SHALL be verified by: locked, then 0x7F held -> invalid_pat pulse, err_count+1, locked=0, digit_out unchanged.
REQ-038 SHALL be verified by: TIMEOUT=16, locked and seg_in static -> locked falls exactly 16 cycles after the last acceptance; 300 alternating errors -> err_count=255.
